// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI target-side byte shifter.
// Oversamples SCLK/CSn/MOSI, one-deep TX buffer, MSB-first.
module spi_slave_shifter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DUMMY_BYTE  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       spi_sclk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       spi_rise,
  output logic       spi_fall,
  output logic       active,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic sclk_s, csn_s, mosi_s;
  logic sclk_q, csn_q;
  logic rise_d, fall_d;
  logic rise_q, fall_q;
  logic lead, trail, smp, shf;

  state_e      state_q, state_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        active_q, active_d;
  logic [7:0]  sout_q, sout_d;
  logic [6:0]  sin_q, sin_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_pend_q, rx_pend_d;
  logic        rx_valid_q, rx_valid_d;
  logic        under_q, under_d;
  logic        reload_q, reload_d;
  logic [7:0]  txbuf_q, txbuf_d;
  logic        txfull_q, txfull_d;
  logic        take;
  logic [7:0]  load_byte;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Bring the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign rise_d = sclk_s & ~sclk_q & ~csn_s;
  assign fall_d = ~sclk_s & sclk_q & ~csn_s;

  // Registered SCLK edge strobes, gated by chip select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= cpol;
      csn_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      csn_q  <= csn_s;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lead  = cpol ? fall_q : rise_q;
  assign trail = cpol ? rise_q : fall_q;
  assign smp   = cpha ? trail : lead;
  assign shf   = cpha ? lead : trail;

  assign load_byte = txfull_q ? txbuf_q : DUMMY_BYTE;

  // Transfer FSM, shift registers and TX buffer next-state.
  always_comb begin
    state_d    = state_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    active_d   = active_q;
    sout_d     = sout_q;
    sin_d      = sin_q;
    bitcnt_d   = bitcnt_q;
    rx_data_d  = rx_data_q;
    rx_pend_d  = 1'b0;
    rx_valid_d = rx_pend_q;
    under_d    = 1'b0;
    reload_d   = reload_q;
    txbuf_d    = txbuf_q;
    txfull_d   = txfull_q;
    take       = 1'b0;

    if (csn_s) begin
      state_d  = IDLE;
      oe_d     = 1'b0;
      active_d = 1'b0;
      bitcnt_d = 3'd0;
      reload_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          oe_d     = 1'b0;
          active_d = 1'b0;
          bitcnt_d = 3'd0;
          reload_d = 1'b0;
          if (csn_q) state_d = LOAD;
        end
        LOAD: begin
          take     = 1'b1;
          bitcnt_d = 3'd0;
          sin_d    = 7'd0;
          reload_d = 1'b0;
          oe_d     = 1'b1;
          active_d = 1'b1;
          if (!cpha) begin
            miso_d = load_byte[7];
            sout_d = {load_byte[6:0], 1'b0};
          end else begin
            sout_d = load_byte;
          end
          state_d = XFER;
        end
        XFER: begin
          if (smp) begin
            sin_d    = {sin_q[5:0], mosi_s};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_d = {sin_q, mosi_s};
              rx_pend_d = 1'b1;
              if (cpha) begin
                take   = 1'b1;
                sout_d = load_byte;
              end else begin
                reload_d = 1'b1;
              end
            end
          end else if (shf) begin
            if (!cpha && reload_q) begin
              take     = 1'b1;
              reload_d = 1'b0;
              miso_d   = load_byte[7];
              sout_d   = {load_byte[6:0], 1'b0};
            end else begin
              miso_d = sout_q[7];
              sout_d = {sout_q[6:0], 1'b0};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (take) begin
      if (txfull_q) txfull_d = 1'b0;
      else          under_d  = 1'b1;
    end
    if (tx_valid && !txfull_q) begin
      txbuf_d  = tx_data;
      txfull_d = 1'b1;
    end
  end

  // Transfer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      active_q   <= 1'b0;
      sout_q     <= 8'd0;
      sin_q      <= 7'd0;
      bitcnt_q   <= 3'd0;
      rx_data_q  <= 8'd0;
      rx_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      under_q    <= 1'b0;
      reload_q   <= 1'b0;
      txbuf_q    <= 8'd0;
      txfull_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      active_q   <= active_d;
      sout_q     <= sout_d;
      sin_q      <= sin_d;
      bitcnt_q   <= bitcnt_d;
      rx_data_q  <= rx_data_d;
      rx_pend_q  <= rx_pend_d;
      rx_valid_q <= rx_valid_d;
      under_q    <= under_d;
      reload_q   <= reload_d;
      txbuf_q    <= txbuf_d;
      txfull_q   <= txfull_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign spi_rise    = rise_q;
  assign spi_fall    = fall_q;
  assign active      = active_q;
  assign tx_ready    = ~txfull_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = under_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: bench acting as SPI master.
// TX model is a byte queue popped at each byte load point.
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst, cpol, cpha, sclk, csn, mosi;
  logic       miso, miso_oe, rise, fall, active;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun;

  spi_slave_shifter dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
    .spi_sclk(sclk), .spi_csn(csn), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(miso_oe),
    .spi_rise(rise), .spi_fall(fall), .active(active),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int rxv_cnt = 0, und_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  logic [7:0] rx_got[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_got.push_back(rx_data);
    end
    if (tx_underrun) und_cnt++;
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
  end

  logic [7:0] mq[$];
  logic [7:0] g_mo[4];
  logic [7:0] g_fd[4];
  logic [7:0] g_mi[4];
  int und_first, und_base;
  logic rdy_first;

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 2000) begin
      cyc(1);
      t++;
    end
    if (!tx_ready) check("push_timeout", 32'd1, 32'd0);
    tx_data  = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic chk_reset();
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_rise", {31'd0, rise}, 32'd0);
    check("rst_fall", {31'd0, fall}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
  endtask

  task automatic master(input int h, input int n);
    for (int b = 0; b < 4; b++) g_mi[b] = 8'd0;
    csn = 1'b0;
    if (!cpha) mosi = g_mo[0][7];
    cyc(h + 4);
    check("sel_active", {31'd0, active}, 32'd1);
    check("sel_oe", {31'd0, miso_oe}, 32'd1);
    und_first = und_cnt - und_base;
    rdy_first = tx_ready;
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (!cpha) begin
          g_mi[b][i] = miso;
          sclk = ~sclk;
          cyc(h);
          sclk = ~sclk;
          if (i > 0) mosi = g_mo[b][i-1];
          else if (b + 1 < n) mosi = g_mo[b+1][7];
          cyc(h);
        end else begin
          sclk = ~sclk;
          mosi = g_mo[b][i];
          cyc(h);
          g_mi[b][i] = miso;
          sclk = ~sclk;
          cyc(h);
        end
      end
    end
    csn = 1'b1;
    cyc(6);
  endtask

  int exp_und, exp_und0;
  logic [7:0] exp_mi[4];

  task automatic run(input bit p, input bit a, input int h, input int n,
                     input int nf_in, input bit dly, input string tg);
    logic [7:0] q[$];
    logic [7:0] v;
    int fi, nf, start, t, rx0, r0, f0;
    bit was_empty;
    q = mq;
    was_empty = (mq.size() == 0);
    fi = 0;
    exp_und = 0;
    exp_und0 = 0;
    for (int k = 0; k < 4; k++) exp_mi[k] = 8'h00;
    if (!dly && q.size() == 0 && fi < nf_in) begin
      q.push_back(g_fd[fi]);
      fi++;
    end
    for (int k = 0; k <= n; k++) begin
      if (k > 0 && q.size() == 0 && fi < nf_in) begin
        q.push_back(g_fd[fi]);
        fi++;
      end
      if (q.size() != 0) v = q.pop_front();
      else begin
        v = 8'hFF;
        exp_und++;
        if (k == 0) exp_und0 = 1;
      end
      if (k < n) exp_mi[k] = v;
    end
    if (q.size() == 0 && fi < nf_in) begin
      q.push_back(g_fd[fi]);
      fi++;
    end
    nf = fi;
    mq = q;

    cpol = p;
    cpha = a;
    sclk = p;
    cyc(6);
    start = 0;
    if (!dly && was_empty && nf > 0) begin
      push(g_fd[0]);
      start = 1;
    end
    und_base = und_cnt;
    rx0 = rxv_cnt;
    r0 = rise_cnt;
    f0 = fall_cnt;
    rx_got.delete();
    fork
      master(h, n);
      begin
        if (dly) begin
          t = 0;
          while (!miso_oe && t < 200) begin
            cyc(1);
            t++;
          end
          if (!miso_oe) check({tg, "_load_timeout"}, 32'd1, 32'd0);
          cyc(2);
        end
        for (int j = start; j < nf; j++) push(g_fd[j]);
      end
    join
    cyc(10);
    check({tg, "_rx_cnt"}, rxv_cnt - rx0, n);
    for (int b = 0; b < n; b++) begin
      if (b < rx_got.size())
        check({tg, "_rx_byte"}, {24'd0, rx_got[b]}, {24'd0, g_mo[b]});
      check({tg, "_miso_byte"}, {24'd0, g_mi[b]}, {24'd0, exp_mi[b]});
    end
    check({tg, "_und_load"}, und_first, exp_und0);
    check({tg, "_und_total"}, und_cnt - und_base, exp_und);
    check({tg, "_rises"}, rise_cnt - r0, 8 * n);
    check({tg, "_falls"}, fall_cnt - f0, 8 * n);
    check({tg, "_tx_ready"}, {31'd0, tx_ready}, {31'd0, (mq.size() == 0)});
    check({tg, "_oe_off"}, {31'd0, miso_oe}, 32'd0);
  endtask

  initial begin
    int rx0, r0, f0, n, nf;
    rst = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    csn = 1'b1;
    mosi = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'd0;
    cyc(4);
    chk_reset();
    rst = 1'b0;
    cyc(4);

    g_mo[0] = 8'h3C;
    g_fd[0] = 8'hA5;
    run(1'b0, 1'b0, 4, 1, 1, 1'b0, "m0");
    check("m0_ready_after_load", {31'd0, rdy_first}, 32'd1);

    g_mo[0] = 8'h81; g_mo[1] = 8'hFE;
    g_fd[0] = 8'h12; g_fd[1] = 8'h34; g_fd[2] = 8'h56;
    run(1'b1, 1'b1, 5, 2, 3, 1'b0, "m3");

    g_mo[0] = 8'($urandom);
    g_fd[0] = 8'h77;
    run(1'b0, 1'b0, 4, 1, 1, 1'b1, "empty");

    cpol = 1'b0;
    cpha = 1'b1;
    sclk = 1'b0;
    cyc(6);
    if (mq.size() != 0) void'(mq.pop_front());
    rx0 = rxv_cnt;
    csn = 1'b0;
    cyc(8);
    for (int e = 0; e < 5; e++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      cyc(4);
    end
    csn = 1'b1;
    cyc(3);
    check("abort_oe", {31'd0, miso_oe}, 32'd0);
    check("abort_active", {31'd0, active}, 32'd0);
    sclk = 1'b0;
    cyc(20);
    check("abort_no_rx", rxv_cnt - rx0, 0);
    g_mo[0] = 8'h5A;
    g_fd[0] = 8'($urandom);
    run(1'b0, 1'b1, 4, 1, 1, 1'b0, "after_abort");

    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, 3));
      nf = int'($urandom_range(0, n + 1));
      for (int k = 0; k < 4; k++) begin
        g_mo[k] = 8'($urandom);
        g_fd[k] = 8'($urandom);
      end
      run(1'($urandom), 1'($urandom), int'($urandom_range(4, 7)),
          n, nf, 1'($urandom), "rnd");
    end

    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    cyc(6);
    rx0 = rxv_cnt;
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int e = 0; e < 8; e++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      cyc(5);
    end
    check("desel_rises", rise_cnt - r0, 0);
    check("desel_falls", fall_cnt - f0, 0);
    check("desel_rx", rxv_cnt - rx0, 0);

    csn = 1'b0;
    cyc(8);
    for (int e = 0; e < 3; e++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      cyc(5);
    end
    rst = 1'b1;
    cyc(1);
    chk_reset();
    csn = 1'b1;
    rst = 1'b0;
    mq.delete();
    sclk = 1'b0;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
SPI slave-side counterpart to the master clock generator. Oversamples an external SCLK/CSn/MOSI with the system clock and recovers one-cycle rise/fall strobes. Shifts received bytes out to a parallel interface and serialises transmit bytes onto MISO. Used wherever a block must be the target of an SPI master, for loopback verification of the master path and for slave-mode peripherals.

Parameters:
SYNC_STAGES, 2, synchroniser flops on spi_sclk, spi_csn and spi_mosi; minimum 2.
DUMMY_BYTE, 8'hFF, byte shifted out on MISO when the TX buffer is empty at byte load.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cpol  in  1  SCLK idle level; static while spi_csn is low
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static while spi_csn is low
spi_sclk  in  1  external SPI clock (asynchronous)
spi_csn  in  1  external chip select, active low (asynchronous)
spi_mosi  in  1  external serial data in (asynchronous)
spi_miso  out  1  serial data out
spi_miso_oe  out  1  MISO output enable
spi_rise  out  1  one-cycle strobe on a synchronised SCLK rising edge while selected
spi_fall  out  1  one-cycle strobe on a synchronised SCLK falling edge while selected
active  out  1  synchronised chip select is asserted
tx_data  in  8  next byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX buffer empty
rx_data  out  8  last received byte, MSB-first
rx_valid  out  1  one-cycle strobe: rx_data updated
tx_underrun  out  1  one-cycle strobe: DUMMY_BYTE loaded because the buffer was empty

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, spi_rise=0, spi_fall=0, active=0, tx_ready=1, rx_data=8'h00, rx_valid=0, tx_underrun=0. Reset also clears the TX buffer, shift registers, bit counter and synchronisers. Synchroniser flops reset to sclk=cpol, csn=1, mosi=0.
- Synchronisation: sclk_s, csn_s and mosi_s are the SYNC_STAGES-deep synchronised versions of the pins. sclk_q is sclk_s delayed by one cycle.
- Edge strobes: spi_rise = sclk_s & ~sclk_q & ~csn_s; spi_fall = ~sclk_s & sclk_q & ~csn_s. Both are registered, so a strobe asserts SYNC_STAGES+1 clk edges after the pin transition. No strobes while deselected.
- Edge roles: leading = rise if cpol=0, else fall. sample_edge = leading if cpha=0, else trailing. shift_edge = the other edge.
- Timing requirement: SCLK high and low times each ≥ SYNC_STAGES+2 clk periods. Violations are unsupported.
- State machine: IDLE, LOAD, XFER.
  - IDLE: entered on reset. active=0, miso_oe=0. On csn_s falling, go to LOAD.
  - LOAD (1 cycle): load the shift-out register from the TX buffer and set tx_ready=1. If the buffer is empty, load DUMMY_BYTE and pulse tx_underrun. bitcnt=0, miso_oe=1, active=1. If cpha=0, drive MISO with bit 7 now; if cpha=1, MISO holds its current value. Go to XFER.
  - XFER, on sample_edge: shift mosi_s into the shift-in LSB and increment bitcnt (3-bit, wraps 7->0). When bitcnt wraps, update rx_data from the full byte in the same cycle and pulse rx_valid in the following cycle.
  - XFER, on shift_edge:
    - cpha=1: drive the next MISO bit. The first shift_edge after LOAD drives bit 7.
    - cpha=0: advance MISO to the next bit, except on the shift_edge after the 8th sample, which reloads from the TX buffer (or DUMMY_BYTE with tx_underrun) and drives the new bit 7.
    - cpha=1: the byte reload happens in the cycle of the 8th sample, so MISO bit 7 is ready for the next leading edge.
  - Any state, csn_s high: go to IDLE next cycle. miso_oe=0, active=0, bitcnt=0, partial byte discarded, no rx_valid, TX buffer untouched.
- Simultaneous events: csn_s deassert and a sample edge in the same cycle → deassert wins, no shift. A tx_valid accept and a buffer consume in the same cycle → the buffer takes the new byte and tx_ready stays 0. rx_valid has no backpressure: the consumer must take rx_data within 8 SCLK periods.
- TX handshake: a byte is accepted when tx_valid & tx_ready. tx_ready goes 0 the next cycle and returns to 1 the cycle after the buffer is consumed. tx_valid while tx_ready=0 is ignored.
- rst asserted mid-transfer: all state returns to reset values next cycle. A transfer already in progress is not resumed; a new csn_s falling edge is required.

Test Plan:
- Mode 0 (cpol=0, cpha=0), clk:SCLK = 8:1, tx byte 8'hA5 preloaded, master sends 8'h3C → one rx_valid with rx_data=8'h3C. MISO bits sampled by the master = 1,0,1,0,0,1,0,1. tx_ready returns to 1 after LOAD.
- Mode 3 (cpol=1, cpha=1), two back-to-back bytes 8'h81, 8'hFE, with TX bytes 8'h12 then 8'h34 provided via handshake → rx_valid twice with the correct data. Master receives 8'h12, 8'h34. No tx_underrun.
- Empty TX buffer, 1-byte transfer in mode 0 → tx_underrun pulses once in LOAD. Master receives 8'hFF.
- CSn deasserted after 5 SCLK edges of a mode 1 byte → no rx_valid, miso_oe=0 within SYNC_STAGES+1 cycles. The next full transfer of 8'h5A is received correctly.
- SCLK toggling with spi_csn=1 → spi_rise, spi_fall and rx_valid all stay 0. Then rst pulsed mid-byte → all outputs return to reset values in the next cycle.
